// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives icache requests and fills the
// fetch/decode pipeline register, handling redirects, flush, freeze and HALT.
module fetch_stage #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        freeze,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_npc,
  output logic        halted
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    RUN,
    HOLD_REDIR,
    HALTED
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] pc_plus4;
  logic            accept;

  logic            fv_d;
  logic [XLEN-1:0] instr_d, fpc_d, fnpc_d;

  // dhit qualifies the pipeline controller only; fetch never looks at it
  logic unused_dhit;
  assign unused_dhit = dhit;

  assign pc_plus4 = pc_q + PC_STEP;
  assign imemaddr = pc_q;

  // An instruction is latched only on a clean hit in RUN with nothing overriding it
  assign accept = (state_q == RUN) && ihit && !freeze && !flush && !redirect_valid;

  // Next-state, PC and fetch/decode register contents
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    fv_d    = 1'b0;
    instr_d = '0;
    fpc_d   = '0;
    fnpc_d  = '0;

    if (redirect_valid && !freeze) begin
      pc_d    = redirect_pc;
      state_d = RUN;
    end else if (redirect_valid && freeze) begin
      pend_d  = redirect_pc;
      state_d = HOLD_REDIR;
    end else if ((state_q == HOLD_REDIR) && !freeze) begin
      pc_d    = pend_q;
      state_d = RUN;
    end else if ((state_q == RUN) && ihit && !freeze) begin
      pc_d = pc_plus4;
      if (accept && (imemload == HALT_WORD)) begin
        state_d = HALTED;
      end
    end

    if (flush) begin
      fv_d = 1'b0;
    end else if (freeze) begin
      fv_d    = fetch_valid;
      instr_d = fetch_instr;
      fpc_d   = fetch_pc;
      fnpc_d  = fetch_npc;
    end else if (accept) begin
      fv_d    = 1'b1;
      instr_d = imemload;
      fpc_d   = pc_q;
      fnpc_d  = pc_plus4;
    end
  end

  // State register; status outputs are registered from the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      pc_q        <= PC_INIT;
      pend_q      <= '0;
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      fetch_pc    <= '0;
      fetch_npc   <= '0;
      imemREN     <= 1'b1;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      fetch_valid <= fv_d;
      fetch_instr <= instr_d;
      fetch_pc    <= fpc_d;
      fetch_npc   <= fnpc_d;
      imemREN     <= (state_d != HALTED);
      halted      <= (state_d == HALTED);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a cycle-level
// behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] PC_INIT   = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0, dhit = 1'b0, freeze = 1'b0, flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0, imemload = '0;
  logic        imemREN, fetch_valid, halted;
  logic [31:0] imemaddr, fetch_instr, fetch_pc, fetch_npc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc = '0, m_pend = '0;
  bit          m_pending = 0, m_halted = 0;
  logic        m_fv = 1'b0;
  logic [31:0] m_fi = '0, m_fp = '0, m_fn = '0;

  fetch_stage #(.PC_INIT(PC_INIT), .HALT_WORD(HALT_WORD)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .freeze(freeze),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imemload(imemload), .imemREN(imemREN), .imemaddr(imemaddr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_npc(fetch_npc), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the fetch rules to the model using the inputs currently driven
  task automatic model_step();
    bit fetching, took;
    logic [31:0] old_pc;
    if (RST) begin
      m_pc = PC_INIT; m_pend = '0; m_pending = 0; m_halted = 0;
      m_fv = 1'b0; m_fi = '0; m_fp = '0; m_fn = '0;
      return;
    end
    old_pc   = m_pc;
    fetching = !m_pending && !m_halted;
    took     = fetching && ihit && !freeze && !flush && !redirect_valid;
    if (flush) begin
      m_fv = 1'b0; m_fi = '0; m_fp = '0; m_fn = '0;
    end else if (!freeze) begin
      m_fv = took;
      m_fi = took ? imemload : 32'h0;
      m_fp = took ? old_pc : 32'h0;
      m_fn = took ? old_pc + 32'd4 : 32'h0;
    end
    if (redirect_valid) begin
      m_halted = 0;
      if (freeze) begin
        m_pend = redirect_pc; m_pending = 1;
      end else begin
        m_pc = redirect_pc; m_pending = 0;
      end
    end else if (m_pending) begin
      if (!freeze) begin
        m_pc = m_pend; m_pending = 0;
      end
    end else if (fetching && ihit && !freeze) begin
      m_pc = old_pc + 32'd4;
      if (took && imemload == HALT_WORD) m_halted = 1;
    end
  endtask

  task automatic check_all();
    chk("imemaddr",    imemaddr,           m_pc);
    chk("imemREN",     32'(imemREN),       32'(!m_halted));
    chk("halted",      32'(halted),        32'(m_halted));
    chk("fetch_valid", 32'(fetch_valid),   32'(m_fv));
    chk("fetch_instr", fetch_instr,        m_fi);
    chk("fetch_pc",    fetch_pc,           m_fp);
    chk("fetch_npc",   fetch_npc,          m_fn);
  endtask

  // One clock: drive at the falling edge, check at the next falling edge
  task automatic cycle(input logic rst, input logic ih, input logic fr, input logic fl,
                       input logic rv, input logic [31:0] rpc, input logic [31:0] ld);
    RST = rst; ihit = ih; freeze = fr; flush = fl;
    redirect_valid = rv; redirect_pc = rpc; imemload = ld;
    dhit = ih;
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    logic [31:0] r;
    // Reset, then three sequential hits
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 32'h1234);
    chk("reset_addr", imemaddr, 32'h0);
    chk("reset_valid", 32'(fetch_valid), 32'h0);
    cycle(0, 1, 0, 0, 0, 0, 32'hA);
    cycle(0, 1, 0, 0, 0, 0, 32'hB);
    cycle(0, 1, 0, 0, 0, 0, 32'hC);
    chk("seq_addr", imemaddr, 32'hC);
    chk("seq_npc", fetch_npc, 32'hC);

    // Miss for two cycles holds the PC at 4
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 32'hA);
    cycle(0, 0, 0, 0, 0, 0, 32'hDEAD);
    cycle(0, 0, 0, 0, 0, 0, 32'hDEAD);
    chk("miss_hold", imemaddr, 32'h4);
    cycle(0, 1, 0, 0, 0, 0, 32'hB);
    chk("miss_latch_pc", fetch_pc, 32'h4);

    // Redirect while hitting at PC 8
    cycle(0, 1, 0, 0, 1, 32'h100, 32'hC);
    chk("redir_addr", imemaddr, 32'h100);
    chk("redir_bubble", 32'(fetch_valid), 32'h0);
    cycle(0, 1, 0, 0, 0, 0, 32'h1111);

    // Redirect captured under a 3-cycle freeze
    cycle(0, 1, 1, 0, 1, 32'h200, 32'h2222);
    cycle(0, 1, 1, 0, 0, 0, 32'h2222);
    cycle(0, 1, 1, 0, 0, 0, 32'h2222);
    chk("frz_hold_addr", imemaddr, 32'h104);
    chk("frz_hold_instr", fetch_instr, 32'h1111);
    cycle(0, 1, 0, 0, 0, 0, 32'h2222);
    chk("frz_redir_addr", imemaddr, 32'h200);

    // Flush with freeze
    cycle(0, 1, 0, 0, 0, 0, 32'h3333);
    cycle(0, 1, 1, 1, 0, 0, 32'h4444);
    chk("flush_frz_valid", 32'(fetch_valid), 32'h0);
    chk("flush_frz_addr", imemaddr, 32'h204);

    // HALT at 0x10, then redirect out of it
    cycle(0, 0, 0, 0, 1, 32'h10, 0);
    cycle(0, 1, 0, 0, 0, 0, HALT_WORD);
    chk("halt_instr", fetch_instr, HALT_WORD);
    chk("halt_flag", 32'(halted), 32'h1);
    cycle(0, 1, 0, 0, 0, 0, 32'h5555);
    chk("halt_addr", imemaddr, 32'h14);
    cycle(0, 0, 0, 0, 1, 32'h40, 0);
    chk("halt_exit", imemaddr, 32'h40);

    // PC wrap
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 1, 0, 0, 0, 0, 32'h6666);
    chk("wrap_npc", fetch_npc, 32'h0);
    chk("wrap_addr", imemaddr, 32'h0);

    // Reset while a redirect is pending
    cycle(0, 1, 1, 0, 1, 32'h300, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 32'h7777);
    chk("rst_pend_addr", imemaddr, PC_INIT + 32'd4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rs, ih, fr, fl, rv;
      logic [31:0] rpc, ld;
      rs  = ($urandom_range(0, 199) == 0);
      ih  = ($urandom_range(0, 3) != 0);
      fr  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      r   = $urandom;
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
      ld  = ($urandom_range(0, 24) == 0) ? HALT_WORD : $urandom;
      cycle(rs, ih, fr, fl, rv, rpc, ld);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
